dmem_hs: RTL

DMEM_HS -- requirements
Module: dmem_hs

---
 rtl/dmem_hs_if.sv | 37 +++
 rtl/dmem_hs.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_hs_if.sv
// dmem_hs_if -- request/response bundle for the dmem_hs data memory.
//
// Purpose: groups the request channel (valid/ready, opcode, address, store
// data) and the response channel (valid/ready, load data, error flag) so
// that the memory and its client connect through a single port.
//
// Port summary (signals carried by the interface):
//   req_valid  1   request present (master -> slave)
//   req_ready  1   slave can accept a request this cycle (slave -> master)
//   req_op     3   LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=5 SW=6 SH=7
//   req_addr   32  byte address
//   req_wdata  32  store data
//   rsp_valid  1   response present (slave -> master)
//   rsp_ready  1   master accepts the response
//   rsp_rdata  32  load result
//   rsp_err    1   access faulted
interface dmem_hs_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_hs.sv
// dmem_hs -- byte-addressed big-endian data memory with valid/ready handshake.
//
// Purpose: accepts one load/store per cycle, answers every accepted request
// with exactly one response one cycle later, holds the response under
// backpressure, flags out-of-range accesses and counts faults (saturating).
//
// Ports:
//   clk      in   1   clock, all state changes on the rising edge
//   rst_n    in   1   synchronous active-low reset
//   bus      slave modport of dmem_hs_if (request/response channels)
//   err_cnt  out  16  saturating count of faulted accesses
//
// Configuration macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned half
// and word accesses fault; otherwise they are performed bytewise.
module dmem_hs #(
    parameter int          DEPTH_BYTES = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_hs_if.slave    bus,
    output logic [15:0] err_cnt
);

    localparam int          AW      = $clog2(DEPTH_BYTES);
    localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);

    typedef enum logic {
        RSP_IDLE,
        RSP_PEND
    } rspState_t;

    rspState_t   r_state;
    rspState_t   w_stateNext;

    logic [7:0]  r_mem [DEPTH_BYTES];
    logic [31:0] r_rspRdata;
    logic        r_rspErr;
    logic [15:0] r_errCnt;

    logic [31:0]   w_offset;
    logic [2:0]    w_size;
    logic [AW-1:0] w_idx0, w_idx1, w_idx2, w_idx3;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;
    logic [31:0]   w_loadData;
    logic          w_rangeFault;
    logic          w_alignFault;
    logic          w_fault;
    logic          w_isStore;
    logic          w_reqReady;
    logic          w_accept;

    // Offset wraps modulo 2^32, so addresses below the base become huge
    // offsets and are caught by the range check.
    assign w_offset  = bus.req_addr - BASE_ADDR;
    assign w_isStore = (bus.req_op >= 3'd5);

    // Access size in bytes from the opcode.
    always_comb begin
        w_size = 3'd4;
        case (bus.req_op)
            3'd0, 3'd1, 3'd5: w_size = 3'd1;
            3'd2, 3'd3, 3'd7: w_size = 3'd2;
            default:          w_size = 3'd4;
        endcase
    end

    // Range check done in 33 bits so offsets near 2^32 cannot wrap into range.
    assign w_rangeFault = ({1'b0, w_offset} + {30'd0, w_size}) > DEPTH33;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_alignFault = ((w_size == 3'd2) && bus.req_addr[0]) ||
                          ((w_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_alignFault = 1'b0;
`endif

    assign w_fault = w_rangeFault || w_alignFault;

    // Consecutive byte indices; misaligned accesses simply walk forward.
    assign w_idx0 = w_offset[AW-1:0];
    assign w_idx1 = w_idx0 + AW'(1);
    assign w_idx2 = w_idx0 + AW'(2);
    assign w_idx3 = w_idx0 + AW'(3);

    assign w_b0 = r_mem[w_idx0];
    assign w_b1 = r_mem[w_idx1];
    assign w_b2 = r_mem[w_idx2];
    assign w_b3 = r_mem[w_idx3];

    // Big-endian assembly: the lowest offset is the most significant byte.
    always_comb begin
        w_loadData = 32'd0;
        case (bus.req_op)
            3'd0:    w_loadData = {{24{w_b0[7]}}, w_b0};
            3'd1:    w_loadData = {24'd0, w_b0};
            3'd2:    w_loadData = {{16{w_b0[7]}}, w_b0, w_b1};
            3'd3:    w_loadData = {16'd0, w_b0, w_b1};
            3'd4:    w_loadData = {w_b0, w_b1, w_b2, w_b3};
            default: w_loadData = 32'd0;
        endcase
    end

    // Requests seen while reset is asserted are never accepted.
    assign w_reqReady    = (r_state == RSP_IDLE) || bus.rsp_ready;
    assign w_accept      = bus.req_valid && w_reqReady && rst_n;
    assign bus.req_ready = w_reqReady;
    assign bus.rsp_valid = (r_state == RSP_PEND);
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_err   = r_rspErr;
    assign err_cnt       = r_errCnt;

    // Response slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A new accept always refills the slot, even on the edge that drains it.
    always_comb begin
        w_stateNext = r_state;
        if (w_accept) begin
            w_stateNext = RSP_PEND;
        end else if ((r_state == RSP_PEND) && bus.rsp_ready) begin
            w_stateNext = RSP_IDLE;
        end
    end

    // Response payload and fault counter; payload only changes on accept,
    // which keeps it stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspRdata <= 32'd0;
            r_rspErr   <= 1'b0;
            r_errCnt   <= 16'd0;
        end else if (w_accept) begin
            r_rspErr   <= w_fault;
            r_rspRdata <= (w_fault || w_isStore) ? 32'd0 : w_loadData;
            if (w_fault && (r_errCnt != 16'hFFFF)) begin
                r_errCnt <= r_errCnt + 16'd1;
            end
        end
    end

    // Array writes on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_isStore && !w_fault) begin
            case (bus.req_op)
                3'd5: begin
                    r_mem[w_idx0] <= bus.req_wdata[7:0];
                end
                3'd7: begin
                    r_mem[w_idx0] <= bus.req_wdata[15:8];
                    r_mem[w_idx1] <= bus.req_wdata[7:0];
                end
                default: begin
                    r_mem[w_idx0] <= bus.req_wdata[31:24];
                    r_mem[w_idx1] <= bus.req_wdata[23:16];
                    r_mem[w_idx2] <= bus.req_wdata[15:8];
                    r_mem[w_idx3] <= bus.req_wdata[7:0];
                end
            endcase
        end
    end

endmodule
